// File: rtl/cla28_resp_checker.sv
// Response-side checker for the CLA adder: re-aligns issued operands with the adder's sum
// across its pipeline latency, compares against a golden modulo-2^WIDTH sum and logs the first failure.
module cla28_resp_checker #(
  parameter int WIDTH = 28,
  parameter int LAT   = 1,
  parameter int NVEC  = 200,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] s_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH-1:0] first_err_s,
  output logic [WIDTH-1:0] first_err_exp
);

  localparam int ISS_W = $clog2(NVEC + 1);
  localparam logic [ISS_W-1:0] NVEC_C  = ISS_W'(NVEC);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [ISS_W-1:0] issued_q, issued_d;
  logic [ISS_W-1:0] cmpd_q, cmpd_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             have_err_q, have_err_d;
  logic [WIDTH-1:0] fa_q, fa_d;
  logic [WIDTH-1:0] fb_q, fb_d;
  logic [WIDTH-1:0] fs_q, fs_d;
  logic [WIDTH-1:0] fe_q, fe_d;

  logic             run_start;
  logic             accept;
  logic             cmp_valid;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic [WIDTH-1:0] cmp_exp;
  logic             mismatch;
  logic             line_busy;

  assign run_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accept    = (state_q == S_RUN) && in_valid && (issued_q < NVEC_C);

  generate
    if (LAT == 0) begin : g_direct
      assign cmp_valid = accept;
      assign cmp_a     = a_in;
      assign cmp_b     = b_in;
      assign line_busy = 1'b0;
    end else begin : g_line
      logic [LAT-1:0]   vld_q;
      logic [WIDTH-1:0] a_q [LAT];
      logic [WIDTH-1:0] b_q [LAT];

      // Operand delay line; it shifts every cycle so it flushes itself outside RUN.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          for (int i = 0; i < LAT; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
          end
        end else begin
          vld_q[0] <= accept;
          a_q[0]   <= a_in;
          b_q[0]   <= b_in;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            a_q[i]   <= a_q[i-1];
            b_q[i]   <= b_q[i-1];
          end
        end
      end

      assign cmp_valid = vld_q[LAT-1];
      assign cmp_a     = a_q[LAT-1];
      assign cmp_b     = b_q[LAT-1];
      assign line_busy = |vld_q;
    end
  endgenerate

  assign cmp_exp  = cmp_a + cmp_b;
  assign mismatch = cmp_valid && (s_dut != cmp_exp);

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    cmpd_d     = cmpd_q;
    vec_cnt_d  = vec_cnt_q;
    err_cnt_d  = err_cnt_q;
    idx_d      = idx_q;
    have_err_d = have_err_q;
    fa_d       = fa_q;
    fb_d       = fb_q;
    fs_d       = fs_q;
    fe_d       = fe_q;

    if (run_start) begin
      state_d    = S_RUN;
      issued_d   = '0;
      cmpd_d     = '0;
      vec_cnt_d  = '0;
      err_cnt_d  = '0;
      idx_d      = '0;
      have_err_d = 1'b0;
      fa_d       = '0;
      fb_d       = '0;
      fs_d       = '0;
      fe_d       = '0;
    end else begin
      if (accept) begin
        issued_d = issued_q + 1'b1;
      end

      if (cmp_valid) begin
        vec_cnt_d = vec_cnt_q + 1'b1;
        cmpd_d    = cmpd_q + 1'b1;
        if (mismatch) begin
          if (err_cnt_q != CNT_MAX) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          // Only the first failing vector of a run is kept for diagnosis.
          if (!have_err_q) begin
            have_err_d = 1'b1;
            idx_d      = vec_cnt_q;
            fa_d       = cmp_a;
            fb_d       = cmp_b;
            fs_d       = s_dut;
            fe_d       = cmp_exp;
          end
        end
      end

      case (state_q)
        S_RUN: begin
          if (issued_d == NVEC_C) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          // cmpd_q is wide enough for NVEC, unlike vec_cnt which may wrap.
          if (!line_busy && (cmpd_q == NVEC_C)) begin
            state_d = S_DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      issued_q   <= '0;
      cmpd_q     <= '0;
      vec_cnt_q  <= '0;
      err_cnt_q  <= '0;
      idx_q      <= '0;
      have_err_q <= 1'b0;
      fa_q       <= '0;
      fb_q       <= '0;
      fs_q       <= '0;
      fe_q       <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      cmpd_q     <= cmpd_d;
      vec_cnt_q  <= vec_cnt_d;
      err_cnt_q  <= err_cnt_d;
      idx_q      <= idx_d;
      have_err_q <= have_err_d;
      fa_q       <= fa_d;
      fb_q       <= fb_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
    end
  end

  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign pass          = done && (err_cnt_q == '0);
  assign vec_cnt       = vec_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = idx_q;
  assign first_err_a   = fa_q;
  assign first_err_b   = fb_q;
  assign first_err_s   = fs_q;
  assign first_err_exp = fe_q;

endmodule

// File: tb/tb_cla28_resp_checker.sv
// Scoreboard bench for cla28_resp_checker: three instances (LAT=1/3/0) fed by a behavioural adder
// with programmable delay and fault injection; expected run results come from a vector-list model.
module tb_cla28_resp_checker;
   localparam int W = 28;
   localparam logic [W-1:0] ALL1 = 28'hFFFFFFF;

   typedef struct {
      int         vec;
      int         err;
      int         idx;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] s;
      logic [W-1:0] x;
      bit         pass;
      bit         loose;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic start [3];
   logic inValid [3];
   logic [W-1:0] aIn [3];
   logic [W-1:0] bIn [3];
   logic [W-1:0] xorF [3];
   logic [W-1:0] sDut [3];
   int adderDelay [3];
   logic [W-1:0] pipe [3][8];

   logic busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
   logic [15:0] vec0, err0, idx0, vec2, err2, idx2;
   logic [3:0] vec1, err1, idx1;
   logic [W-1:0] fa0, fb0, fs0, fe0, fa1, fb1, fs1, fe1, fa2, fb2, fs2, fe2;

   int checks = 0;
   int errors = 0;
   exp_t q0 [$];
   exp_t q1 [$];
   exp_t q2 [$];

   // Free-running clock
   always #5 clk = ~clk;

   // Behavioural adder: sum (optionally corrupted) delayed by adderDelay cycles
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         pipe[k][0] <= (aIn[k] + bIn[k]) ^ xorF[k];
         for (int i = 1; i < 8; i++) pipe[k][i] <= pipe[k][i-1];
      end
   end

   // Adder output mux selecting the configured latency
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         sDut[k] = '0;
         if (adderDelay[k] == 0) sDut[k] = (aIn[k] + bIn[k]) ^ xorF[k];
         else sDut[k] = pipe[k][adderDelay[k]-1];
      end
   end

   cla28_resp_checker #(.WIDTH(W), .LAT(1), .NVEC(200), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .in_valid(inValid[0]), .a_in(aIn[0]), .b_in(bIn[0]),
      .s_dut(sDut[0]), .busy(busy0), .done(done0), .pass(pass0), .vec_cnt(vec0), .err_cnt(err0),
      .first_err_idx(idx0), .first_err_a(fa0), .first_err_b(fb0), .first_err_s(fs0), .first_err_exp(fe0));

   cla28_resp_checker #(.WIDTH(W), .LAT(3), .NVEC(20), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .in_valid(inValid[1]), .a_in(aIn[1]), .b_in(bIn[1]),
      .s_dut(sDut[1]), .busy(busy1), .done(done1), .pass(pass1), .vec_cnt(vec1), .err_cnt(err1),
      .first_err_idx(idx1), .first_err_a(fa1), .first_err_b(fb1), .first_err_s(fs1), .first_err_exp(fe1));

   cla28_resp_checker #(.WIDTH(W), .LAT(0), .NVEC(4), .CNT_W(16)) dut2 (
      .clk(clk), .rst(rst), .start(start[2]), .in_valid(inValid[2]), .a_in(aIn[2]), .b_in(bIn[2]),
      .s_dut(sDut[2]), .busy(busy2), .done(done2), .pass(pass2), .vec_cnt(vec2), .err_cnt(err2),
      .first_err_idx(idx2), .first_err_a(fa2), .first_err_b(fb2), .first_err_s(fs2), .first_err_exp(fe2));

   // Single comparison: counts it and reports a failure line when the values differ
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Compares one finished run against the scoreboard record
   task automatic compareRecord(input string tag, input exp_t e, input int vec, input int err, input int idx,
                                input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s,
                                input logic [W-1:0] x, input bit pass);
      checkOutput({tag, " vec_cnt"}, 64'(vec), 64'(e.vec));
      if (e.loose) begin
         checkOutput({tag, " err_cnt nonzero"}, 64'(err != 0), 64'd1);
         checkOutput({tag, " pass"}, 64'(pass), 64'd0);
      end else begin
         checkOutput({tag, " err_cnt"}, 64'(err), 64'(e.err));
         checkOutput({tag, " first_err_idx"}, 64'(idx), 64'(e.idx));
         checkOutput({tag, " first_err_a"}, 64'(a), 64'(e.a));
         checkOutput({tag, " first_err_b"}, 64'(b), 64'(e.b));
         checkOutput({tag, " first_err_s"}, 64'(s), 64'(e.s));
         checkOutput({tag, " first_err_exp"}, 64'(x), 64'(e.x));
         checkOutput({tag, " pass"}, 64'(pass), 64'(e.pass));
      end
   endtask

   function automatic logic getDone(input int k);
      case (k)
         0: return done0;
         1: return done1;
         default: return done2;
      endcase
   endfunction

   function automatic logic getBusy(input int k);
      case (k)
         0: return busy0;
         1: return busy1;
         default: return busy2;
      endcase
   endfunction

   // Monitors: pop the expected record whenever an instance raises done
   bit prevDone0 = 1'b0, prevDone1 = 1'b0, prevDone2 = 1'b0;
   exp_t m0, m1, m2;

   always @(negedge clk) begin
      if (done0 && !prevDone0) begin
         if (q0.size() == 0) checkOutput("dut0 unexpected done", 64'd1, 64'd0);
         else begin
            m0 = q0.pop_front();
            compareRecord("dut0", m0, int'(vec0), int'(err0), int'(idx0), fa0, fb0, fs0, fe0, pass0);
         end
      end
      prevDone0 <= done0;
   end

   always @(negedge clk) begin
      if (done1 && !prevDone1) begin
         if (q1.size() == 0) checkOutput("dut1 unexpected done", 64'd1, 64'd0);
         else begin
            m1 = q1.pop_front();
            compareRecord("dut1", m1, int'(vec1), int'(err1), int'(idx1), fa1, fb1, fs1, fe1, pass1);
         end
      end
      prevDone1 <= done1;
   end

   always @(negedge clk) begin
      if (done2 && !prevDone2) begin
         if (q2.size() == 0) checkOutput("dut2 unexpected done", 64'd1, 64'd0);
         else begin
            m2 = q2.pop_front();
            compareRecord("dut2", m2, int'(vec2), int'(err2), int'(idx2), fa2, fb2, fs2, fe2, pass2);
         end
      end
      prevDone2 <= done2;
   end

   // One run: build the vector list, model the expected result, push it, then drive the adder.
   // mode 0 random clean, 1 A=all-ones/B=index clean, 2 as 1 with faults at B=5,9,
   // 3 random with sparse faults, 4 random with every vector faulty.
   task automatic applyStimulus(input int k, input int nvec, input int cntW, input int lat, input int mode,
                                input int nOffer, input bit gaps, input bit pokeStart, input int delay);
      logic [W-1:0] va [$];
      logic [W-1:0] vb [$];
      logic [W-1:0] vx [$];
      logic [W-1:0] a, b, x, gold;
      exp_t e;
      int errs, t, doneT, lastAcc, maxc;
      bit found;
      for (int j = 0; j < nOffer; j++) begin
         a = W'($urandom);
         b = W'($urandom);
         x = '0;
         case (mode)
            1, 2: begin
               a = ALL1;
               b = W'(j);
               if (mode == 2 && (j == 5 || j == 9)) x = W'(4);
            end
            3: if ($urandom_range(0, 7) == 0) x = W'($urandom) | W'(1);
            4: x = W'($urandom) | W'(1);
            default: x = '0;
         endcase
         va.push_back(a);
         vb.push_back(b);
         vx.push_back(x);
      end

      maxc = (1 << cntW) - 1;
      errs = 0;
      found = 1'b0;
      e.vec = nvec % (1 << cntW);
      e.idx = 0;
      e.a = '0;
      e.b = '0;
      e.s = '0;
      e.x = '0;
      for (int j = 0; j < nvec; j++) begin
         gold = va[j] + vb[j];
         if ((gold ^ vx[j]) != gold) begin
            if (!found) begin
               found = 1'b1;
               e.idx = j % (1 << cntW);
               e.a = va[j];
               e.b = vb[j];
               e.s = gold ^ vx[j];
               e.x = gold;
            end
            errs++;
         end
      end
      e.err = (errs > maxc) ? maxc : errs;
      e.pass = (errs == 0);
      e.loose = (delay != lat);
      case (k)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase

      adderDelay[k] = delay;
      @(negedge clk);
      // Operand offered together with start must not be accepted; its corrupt sum would show.
      start[k] = 1'b1;
      inValid[k] = 1'b1;
      aIn[k] = W'($urandom);
      bIn[k] = W'($urandom);
      xorF[k] = W'(28'h123);
      @(negedge clk);
      start[k] = 1'b0;
      checkOutput($sformatf("dut%0d busy after start", k), 64'(getBusy(k)), 64'd1);
      checkOutput($sformatf("dut%0d done after start", k), 64'(getDone(k)), 64'd0);

      t = 0;
      doneT = -1;
      lastAcc = 0;
      for (int j = 0; j < nOffer; j++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               inValid[k] = 1'b0;
               xorF[k] = '0;
               @(negedge clk);
               t++;
               if (doneT < 0 && getDone(k)) doneT = t;
            end
         end
         inValid[k] = 1'b1;
         aIn[k] = va[j];
         bIn[k] = vb[j];
         xorF[k] = vx[j];
         start[k] = pokeStart && (j == 2);
         if (j == nvec - 1) lastAcc = t;
         @(negedge clk);
         t++;
         start[k] = 1'b0;
         if (doneT < 0 && getDone(k)) doneT = t;
      end
      inValid[k] = 1'b0;
      xorF[k] = '0;
      for (int c = 0; c < 200 && doneT < 0; c++) begin
         @(negedge clk);
         t++;
         if (getDone(k)) doneT = t;
      end
      if (doneT < 0) checkOutput($sformatf("dut%0d done timeout", k), 64'd0, 64'd1);
      else checkOutput($sformatf("dut%0d done latency", k), 64'(doneT), 64'(lastAcc + lat + 2));
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int c;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         start[k] = 1'b0;
         inValid[k] = 1'b0;
         aIn[k] = '0;
         bIn[k] = '0;
         xorF[k] = '0;
         adderDelay[k] = 0;
      end
      adderDelay[0] = 1;
      adderDelay[1] = 3;
      #12;
      checkOutput("reset busy0", 64'(busy0), 64'd0);
      checkOutput("reset done0", 64'(done0), 64'd0);
      checkOutput("reset pass0", 64'(pass0), 64'd0);
      checkOutput("reset vec0", 64'(vec0), 64'd0);
      checkOutput("reset fe0", 64'(fe0), 64'd0);
      checkOutput("reset done1", 64'(done1), 64'd0);
      checkOutput("reset done2", 64'(done2), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Asynchronous reset in the middle of a run once 37 vectors have been compared
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      c = 0;
      while (vec0 != 16'd37 && c < 100) begin
         inValid[0] = 1'b1;
         aIn[0] = W'($urandom);
         bIn[0] = W'($urandom);
         xorF[0] = (c == 3) ? W'(1) : W'(0);
         @(negedge clk);
         c++;
      end
      checkOutput("midrun reached vec 37", 64'(vec0), 64'd37);
      #2 rst = 1'b1;
      #1;
      checkOutput("midrun reset busy", 64'(busy0), 64'd0);
      checkOutput("midrun reset vec_cnt", 64'(vec0), 64'd0);
      checkOutput("midrun reset err_cnt", 64'(err0), 64'd0);
      checkOutput("midrun reset first_err_a", 64'(fa0), 64'd0);
      checkOutput("midrun reset first_err_s", 64'(fs0), 64'd0);
      inValid[0] = 1'b0;
      xorF[0] = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post reset busy", 64'(busy0), 64'd0);

      applyStimulus(0, 200, 16, 1, 1, 200, 1'b0, 1'b0, 1);
      applyStimulus(0, 200, 16, 1, 2, 200, 1'b0, 1'b0, 1);
      applyStimulus(0, 200, 16, 1, 3, 205, 1'b1, 1'b1, 1);
      applyStimulus(1, 20, 4, 3, 0, 20, 1'b1, 1'b0, 3);
      applyStimulus(1, 20, 4, 3, 0, 20, 1'b0, 1'b0, 2);
      applyStimulus(1, 20, 4, 3, 4, 22, 1'b0, 1'b0, 3);
      applyStimulus(2, 4, 16, 0, 0, 6, 1'b1, 1'b0, 0);
      applyStimulus(2, 4, 16, 0, 3, 5, 1'b1, 1'b1, 0);
      applyStimulus(2, 4, 16, 0, 4, 4, 1'b0, 1'b0, 0);

      checkOutput("dut0 scoreboard drained", 64'(q0.size()), 64'd0);
      checkOutput("dut1 scoreboard drained", 64'(q1.size()), 64'd0);
      checkOutput("dut2 scoreboard drained", 64'(q2.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
